lc4_rob_ctrl: RTL and testbench
===============================

Name: lc4_rob_ctrl

Overview:
- Bookkeeping controller for the 4-entry in-order reorder buffer / issue queue feeding the issue stage.
- Allocates entries at the tail on dispatch and marks entries issued when the issue stage selects them.
- Marks entries complete on writeback and retires them in order from the head.
- Squashes younger entries on branch mispredict.
- Produces the iq_valid/iq_issue/iq_commit/iq_rd status vectors consumed by the issue queue.

Parameters:
- none; queue depth is fixed at 4 entries with 2-bit indices.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- gwe  in  1  global write enable; all state updates are qualified by gwe=1
- dispatch_req  in  1  decode presents a new instruction
- dispatch_stall  out  1  queue full; dispatch not accepted
- dispatch_index  out  2  entry the dispatched instruction occupies (tail)
- is_valid  in  1  issue stage selected an entry this cycle
- is_rob_index  in  2  index of the issued entry
- done_valid  in  1  an entry finished execution/writeback
- done_index  in  2  index of the completed entry
- flush  in  1  mispredict squash request
- flush_index  in  2  mispredicted entry; it is kept, every younger entry is squashed
- commit_valid  out  1  head entry retires at the next enabled edge
- commit_index  out  2  head index being retired
- iq_valid  out  4  per-entry allocated bit
- iq_issue  out  4  per-entry issued bit
- iq_commit  out  4  per-entry completed (ready-to-retire) bit
- iq_rd  out  2  head pointer (oldest entry)
- iq_count  out  3  occupancy, 0..4

Behaviour:
- State: head[1:0], tail[1:0], count[2:0], valid/issued/done[3:0]. iq_* outputs are direct register outputs.
- Reset (rst=1 at an edge, overriding gwe): head=tail=0, count=0, all bit vectors 0. Resulting outputs: dispatch_stall=0, commit_valid=0, dispatch_index=0, iq_rd=0, iq_count=0.
- gwe=0: no state changes. Combinational outputs still track the current state.
- dispatch_stall = (count==4). A full queue stalls even if commit_valid=1 that cycle; there is no same-cycle retire bypass.
- dispatch_index = tail.
- Dispatch is accepted when dispatch_req & ~dispatch_stall & ~flush. On acceptance: valid[tail]=1, issued[tail]=0, done[tail]=0, tail=tail+1 (mod 4 wrap).
- Issue: when is_valid & valid[is_rob_index], set issued[is_rob_index]. Issue to an invalid entry is ignored.
- Complete: when done_valid & valid[done_index] & (issued[done_index] | same-cycle issue of that index), set done[done_index]. Otherwise ignored.
- commit_valid = valid[head] & done[head], combinational. commit_index = head. On an enabled edge with commit_valid=1: clear valid/issued/done[head], head=head+1.
- count update: count + accepted_dispatch − commit_valid. Simultaneous dispatch and commit leave count unchanged.
- Flush is acted on only when valid[flush_index]; otherwise it is ignored entirely, and a dispatch in that cycle is still blocked.
- Effect of an acted-on flush:
  - Clear all bits of entries strictly younger than flush_index, walking from flush_index+1 up to tail−1 (mod 4).
  - tail = flush_index+1.
  - count = ((flush_index−head) mod 4) + 1 − commit_valid.
  - Issue/complete writes targeting squashed entries are dropped in the same cycle.
  - Writes to surviving entries and commit proceed normally.
- Flush with flush_index == head while the head commits in the same cycle: the queue becomes empty and head = tail = flush_index+1.
- All pointer arithmetic is 2-bit modulo 4. Full versus empty is distinguished only by count.
- No latency beyond one cycle: every update is visible on the outputs the cycle after the enabled edge.

Test Plan:
- Reset then idle: iq_valid=0000, iq_count=0, dispatch_stall=0, commit_valid=0, iq_rd=0.
- Four consecutive dispatches: dispatch_index sequence 0,1,2,3; iq_valid=1111, iq_count=4, dispatch_stall=1. A fifth dispatch_req is ignored and state is unchanged.
- Issue entries 2,0,1; complete entries 2 then 1: commit_valid stays 0. Complete entry 0: commit_valid=1 with commit_index=0, then 1, then 2 on successive cycles; iq_rd=3, iq_count=1.
- Wrap-around: head=3, tail=3 empty; dispatch 3 instructions → entries 3,0,1; tail=2, iq_count=3. Commit them all; iq_rd ends at 2.
- Flush: entries 0..3 valid with head=0; flush with flush_index=1 → iq_valid=0011, tail=2, iq_count=2. A same-cycle done_index=3 is dropped. Repeat with flush_index=0 while entry 0 commits → iq_count=0, iq_rd=1, dispatch_index=1.
- gwe=0 while dispatch_req, is_valid, done_valid and flush are all asserted: no state change. The same stimulus with gwe=1 updates state; rst=1 with gwe=0 still clears all state.

Source files
------------

// File: rtl/lc4_rob_ctrl.sv
// lc4_rob_ctrl: head/tail bookkeeping for the 4-entry in-order reorder buffer.
// Tracks allocate/issue/complete/retire per entry and squashes on mispredict.
module lc4_rob_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       gwe,
    input  logic       dispatch_req,
    output logic       dispatch_stall,
    output logic [1:0] dispatch_index,
    input  logic       is_valid,
    input  logic [1:0] is_rob_index,
    input  logic       done_valid,
    input  logic [1:0] done_index,
    input  logic       flush,
    input  logic [1:0] flush_index,
    output logic       commit_valid,
    output logic [1:0] commit_index,
    output logic [3:0] iq_valid,
    output logic [3:0] iq_issue,
    output logic [3:0] iq_commit,
    output logic [1:0] iq_rd,
    output logic [2:0] iq_count
);

    logic [1:0] head, tail;
    logic [2:0] count;
    logic [3:0] valid, issued, done;

    logic [1:0] head_n, tail_n;
    logic [2:0] count_n;
    logic [3:0] valid_n, issued_n, done_n;
    logic [3:0] squash;
    logic [1:0] flush_age;
    logic       flush_act, disp_acc, issue_hit, done_hit;

    assign dispatch_stall = (count == 3'd4);
    assign dispatch_index = tail;
    assign commit_valid   = valid[head] & done[head];
    assign commit_index   = head;
    assign iq_valid       = valid;
    assign iq_issue       = issued;
    assign iq_commit      = done;
    assign iq_rd          = head;
    assign iq_count       = count;

    always_comb begin
        flush_act = flush & valid[flush_index];
        flush_age = flush_index - head;
        // Valid entries are contiguous from head, so "younger" is an age compare.
        for (int i = 0; i < 4; i++) begin
            squash[i] = flush_act & valid[i]
                      & (2'(2'(i) - head) > flush_age);
        end

        disp_acc  = dispatch_req & ~dispatch_stall & ~flush;
        issue_hit = is_valid & valid[is_rob_index]
                  & ~squash[is_rob_index];
        done_hit  = done_valid & valid[done_index]
                  & ~squash[done_index]
                  & (issued[done_index]
                     | (issue_hit & (is_rob_index == done_index)));

        valid_n  = valid & ~squash;
        issued_n = issued & ~squash;
        done_n   = done & ~squash;

        if (disp_acc) begin
            valid_n[tail]  = 1'b1;
            issued_n[tail] = 1'b0;
            done_n[tail]   = 1'b0;
        end
        if (issue_hit) issued_n[is_rob_index] = 1'b1;
        if (done_hit)  done_n[done_index] = 1'b1;
        if (commit_valid) begin
            valid_n[head]  = 1'b0;
            issued_n[head] = 1'b0;
            done_n[head]   = 1'b0;
        end

        head_n = head + {1'b0, commit_valid};
        if (flush_act) begin
            tail_n  = flush_index + 2'd1;
            count_n = {1'b0, flush_age} + 3'd1 - {2'b00, commit_valid};
        end else begin
            tail_n  = tail + {1'b0, disp_acc};
            count_n = count + {2'b00, disp_acc} - {2'b00, commit_valid};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head   <= 2'd0;
            tail   <= 2'd0;
            count  <= 3'd0;
            valid  <= 4'd0;
            issued <= 4'd0;
            done   <= 4'd0;
        end else if (gwe) begin
            head   <= head_n;
            tail   <= tail_n;
            count  <= count_n;
            valid  <= valid_n;
            issued <= issued_n;
            done   <= done_n;
        end
    end

endmodule

// File: tb/tb_lc4_rob_ctrl.sv
// Bench for lc4_rob_ctrl: directed vector table, hand-written corner
// sequences, then random traffic against a queue-based reference model.
module tb_lc4_rob_ctrl;

    logic       clk = 1'b0;
    logic       rst, gwe, dispatch_req, is_valid, done_valid, flush;
    logic [1:0] is_rob_index, done_index, flush_index;
    logic       dispatch_stall, commit_valid;
    logic [1:0] dispatch_index, commit_index, iq_rd;
    logic [3:0] iq_valid, iq_issue, iq_commit;
    logic [2:0] iq_count;

    int checks = 0;
    int failures = 0;

    lc4_rob_ctrl dut (
        .clk(clk), .rst(rst), .gwe(gwe),
        .dispatch_req(dispatch_req), .dispatch_stall(dispatch_stall),
        .dispatch_index(dispatch_index),
        .is_valid(is_valid), .is_rob_index(is_rob_index),
        .done_valid(done_valid), .done_index(done_index),
        .flush(flush), .flush_index(flush_index),
        .commit_valid(commit_valid), .commit_index(commit_index),
        .iq_valid(iq_valid), .iq_issue(iq_issue), .iq_commit(iq_commit),
        .iq_rd(iq_rd), .iq_count(iq_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       g, req, isv;
        logic [1:0] isi;
        logic       dv;
        logic [1:0] di;
        logic       fl;
        logic [1:0] fi;
        logic       stall;
        logic [1:0] didx;
        logic       cv;
        logic [1:0] cidx;
        logic [3:0] v, iss, cmt;
        logic [1:0] rd;
        logic [2:0] cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic g, req, isv, input logic [1:0] isi,
                       input logic dv, input logic [1:0] di,
                       input logic fl, input logic [1:0] fi,
                       input logic stall, input logic [1:0] didx,
                       input logic cv, input logic [1:0] cidx,
                       input logic [3:0] v, iss, cmt,
                       input logic [1:0] rd, input logic [2:0] cnt);
        vec_t r;
        r.g = g; r.req = req; r.isv = isv; r.isi = isi;
        r.dv = dv; r.di = di; r.fl = fl; r.fi = fi;
        r.stall = stall; r.didx = didx; r.cv = cv; r.cidx = cidx;
        r.v = v; r.iss = iss; r.cmt = cmt; r.rd = rd; r.cnt = cnt;
        tbl.push_back(r);
    endtask

    task automatic chk(input string nm, input logic [7:0] a,
                       input logic [7:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, a, e);
        end
    endtask

    task automatic check_outs(input string tag, input logic stall,
                              input logic [1:0] didx, input logic cv,
                              input logic [1:0] cidx,
                              input logic [3:0] v, iss, cmt,
                              input logic [1:0] rd, input logic [2:0] cnt);
        chk({tag, ".stall"}, 8'(dispatch_stall), 8'(stall));
        chk({tag, ".didx"}, 8'(dispatch_index), 8'(didx));
        chk({tag, ".cv"}, 8'(commit_valid), 8'(cv));
        chk({tag, ".cidx"}, 8'(commit_index), 8'(cidx));
        chk({tag, ".valid"}, 8'(iq_valid), 8'(v));
        chk({tag, ".issue"}, 8'(iq_issue), 8'(iss));
        chk({tag, ".commit"}, 8'(iq_commit), 8'(cmt));
        chk({tag, ".rd"}, 8'(iq_rd), 8'(rd));
        chk({tag, ".count"}, 8'(iq_count), 8'(cnt));
    endtask

    task automatic drive(input logic g, req, isv, input logic [1:0] isi,
                         input logic dv, input logic [1:0] di,
                         input logic fl, input logic [1:0] fi);
        gwe = g; dispatch_req = req; is_valid = isv; is_rob_index = isi;
        done_valid = dv; done_index = di; flush = fl; flush_index = fi;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
    endtask

    task automatic fill(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1, 1, 0, 0, 0, 0, 0, 0);
            tick();
        end
        idle();
    endtask

    // Reference model: oldest-first list of occupied indices plus per-index flags.
    int oq[$];
    int mh;
    bit mi[4];
    bit md[4];

    function automatic int find(input int idx);
        for (int k = 0; k < oq.size(); k++)
            if (oq[k] == idx) return k;
        return -1;
    endfunction

    task automatic m_step(input logic r, g, req, isv, input logic [1:0] isi,
                          input logic dv, input logic [1:0] di,
                          input logic fl, input logic [1:0] fi);
        int n, fp, keep, ip, dp, t, x;
        bit cv, iok, dok, dacc;
        if (r) begin
            mh = 0;
            oq.delete();
            for (int k = 0; k < 4; k++) begin mi[k] = 0; md[k] = 0; end
            return;
        end
        if (!g) return;
        n    = oq.size();
        cv   = (n > 0) && md[oq[0]];
        fp   = find(int'(fi));
        keep = (fl && fp >= 0) ? fp + 1 : n;
        ip   = find(int'(isi));
        dp   = find(int'(di));
        iok  = isv && ip >= 0 && ip < keep;
        dok  = dv && dp >= 0 && dp < keep
               && (mi[di] || (iok && isi == di));
        dacc = req && n < 4 && !fl;
        t    = (mh + n) % 4;
        while (oq.size() > keep) begin
            x = oq.pop_back();
            mi[x] = 0; md[x] = 0;
        end
        if (iok) mi[isi] = 1;
        if (dok) md[di] = 1;
        if (dacc) begin
            oq.push_back(t);
            mi[t] = 0; md[t] = 0;
        end
        if (cv) begin
            x = oq.pop_front();
            mi[x] = 0; md[x] = 0;
            mh = (mh + 1) % 4;
        end
    endtask

    task automatic m_check(input string tag);
        logic [3:0] v, iss, cmt;
        logic       cv;
        v = 0; iss = 0; cmt = 0;
        foreach (oq[k]) begin
            v[oq[k]]   = 1'b1;
            iss[oq[k]] = mi[oq[k]];
            cmt[oq[k]] = md[oq[k]];
        end
        cv = (oq.size() > 0) && md[oq[0]];
        check_outs(tag, oq.size() == 4, 2'((mh + oq.size()) % 4), cv,
                   2'(mh), v, iss, cmt, 2'(mh), 3'(oq.size()));
    endtask

    initial begin
        rst = 1'b0;
        idle();

        // g req isv isi dv di fl fi | stall didx cv cidx v iss cmt rd cnt
        add(1,0,0,0,0,0,0,0, 0,0,0,0, 4'b0000,4'b0000,4'b0000, 0,0);
        add(1,1,0,0,0,0,0,0, 0,1,0,0, 4'b0001,4'b0000,4'b0000, 0,1);
        add(1,1,0,0,0,0,0,0, 0,2,0,0, 4'b0011,4'b0000,4'b0000, 0,2);
        add(1,1,0,0,0,0,0,0, 0,3,0,0, 4'b0111,4'b0000,4'b0000, 0,3);
        add(1,1,0,0,0,0,0,0, 1,0,0,0, 4'b1111,4'b0000,4'b0000, 0,4);
        add(1,1,0,0,0,0,0,0, 1,0,0,0, 4'b1111,4'b0000,4'b0000, 0,4);
        add(1,0,1,2,0,0,0,0, 1,0,0,0, 4'b1111,4'b0100,4'b0000, 0,4);
        add(1,0,1,0,0,0,0,0, 1,0,0,0, 4'b1111,4'b0101,4'b0000, 0,4);
        add(1,0,1,1,0,0,0,0, 1,0,0,0, 4'b1111,4'b0111,4'b0000, 0,4);
        add(1,0,0,0,1,2,0,0, 1,0,0,0, 4'b1111,4'b0111,4'b0100, 0,4);
        add(1,0,0,0,1,1,0,0, 1,0,0,0, 4'b1111,4'b0111,4'b0110, 0,4);
        add(1,0,0,0,1,0,0,0, 1,0,1,0, 4'b1111,4'b0111,4'b0111, 0,4);
        add(1,0,0,0,0,0,0,0, 0,0,1,1, 4'b1110,4'b0110,4'b0110, 1,3);
        add(1,0,0,0,0,0,0,0, 0,0,1,2, 4'b1100,4'b0100,4'b0100, 2,2);
        add(1,0,0,0,0,0,0,0, 0,0,0,3, 4'b1000,4'b0000,4'b0000, 3,1);
        add(0,1,1,3,1,3,0,0, 0,0,0,3, 4'b1000,4'b0000,4'b0000, 3,1);

        do_reset();
        check_outs("reset", 0, 0, 0, 0, 4'b0, 4'b0, 4'b0, 0, 0);
        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].g, tbl[k].req, tbl[k].isv, tbl[k].isi,
                  tbl[k].dv, tbl[k].di, tbl[k].fl, tbl[k].fi);
            tick();
            check_outs($sformatf("vec%0d", k), tbl[k].stall, tbl[k].didx,
                       tbl[k].cv, tbl[k].cidx, tbl[k].v, tbl[k].iss,
                       tbl[k].cmt, tbl[k].rd, tbl[k].cnt);
        end

        // Wrap-around: drain to head=tail=3, then allocate 3,0,1.
        do_reset();
        fill(3);
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 1, 2'(k), 1, 2'(k), 0, 0);
            tick();
        end
        idle();
        tick();
        check_outs("wrap_empty", 0, 3, 0, 3, 4'b0, 4'b0, 4'b0, 3, 0);
        fill(3);
        check_outs("wrap_fill", 0, 2, 0, 3, 4'b1011, 4'b0, 4'b0, 3, 3);
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 1, 2'((k + 3) % 4), 1, 2'((k + 3) % 4), 0, 0);
            tick();
        end
        idle();
        tick();
        check_outs("wrap_drain", 0, 2, 0, 2, 4'b0, 4'b0, 4'b0, 2, 0);

        // Flush keeping entry 1; done on squashed entry 3 is dropped.
        do_reset();
        fill(4);
        drive(1, 0, 1, 3, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 1, 3, 1, 1);
        tick();
        check_outs("flush1", 0, 2, 0, 0, 4'b0011, 4'b0, 4'b0, 0, 2);
        drive(1, 1, 0, 0, 0, 0, 1, 3);
        tick();
        check_outs("flush_inv", 0, 2, 0, 0, 4'b0011, 4'b0, 4'b0, 0, 2);

        // Flush at head while head commits: queue empties at index 1.
        do_reset();
        fill(4);
        drive(1, 0, 1, 0, 1, 0, 0, 0);
        tick();
        check_outs("pre_flush0", 1, 0, 1, 0, 4'b1111, 4'b0001, 4'b0001, 0, 4);
        drive(1, 0, 0, 0, 0, 0, 1, 0);
        tick();
        check_outs("flush0", 0, 1, 0, 1, 4'b0, 4'b0, 4'b0, 1, 0);

        // Global write enable gating, and reset overriding it.
        do_reset();
        fill(2);
        drive(0, 1, 1, 1, 1, 1, 1, 1);
        tick();
        check_outs("gwe0", 0, 2, 0, 0, 4'b0011, 4'b0, 4'b0, 0, 2);
        drive(1, 1, 1, 1, 1, 1, 1, 1);
        tick();
        check_outs("gwe1", 0, 2, 0, 0, 4'b0011, 4'b0010, 4'b0010, 0, 2);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        check_outs("rst_gwe0", 0, 0, 0, 0, 4'b0, 4'b0, 4'b0, 0, 0);

        // Random traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            logic r, g, req, isv, dv, fl;
            logic [1:0] isi, di, fi;
            r   = (c == 0) || ($urandom_range(0, 59) == 0);
            g   = $urandom_range(0, 9) != 0;
            req = $urandom_range(0, 1) == 1;
            isv = $urandom_range(0, 1) == 1;
            dv  = $urandom_range(0, 9) < 6;
            fl  = $urandom_range(0, 11) == 0;
            isi = 2'($urandom_range(0, 3));
            di  = 2'($urandom_range(0, 3));
            fi  = 2'($urandom_range(0, 3));
            rst = r;
            drive(g, req, isv, isi, dv, di, fl, fi);
            @(posedge clk);
            m_step(r, g, req, isv, isi, dv, di, fl, fi);
            #1;
            m_check($sformatf("rand%0d", c));
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
